// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-addressed main-memory port between the
// instruction cache (port 0) and the data cache (port 1), with an ack timeout.
module mem_arbiter #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c0_read_ce,
    input  logic          c0_write_ce,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_read_fin,
    output logic          c0_write_fin,
    output logic [DW-1:0] c0_rdata,
    input  logic          c1_read_ce,
    input  logic          c1_write_ce,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_read_fin,
    output logic          c1_write_fin,
    output logic [DW-1:0] c1_rdata,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          timeout_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic          last_grant;
    logic          owner;
    logic [CW-1:0] wait_cnt;

    logic          req0;
    logic          req1;
    logic          grant1;
    logic          aborting;
    logic          finishing;
    logic [DW-1:0] capture_data;

    assign req0 = c0_read_ce | c0_write_ce;
    assign req1 = c1_read_ce | c1_write_ce;

    // On a tie the port that did not win last time is granted, so neither starves.
    assign grant1 = req1 & (~req0 | ~last_grant);

    // The wait counter holds the number of completed BUSY cycles without ack.
    assign aborting     = (TIMEOUT != 0) && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));
    assign finishing    = mem_ack | aborting;
    assign capture_data = mem_ack ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            wait_cnt     <= '0;
            mem_ce       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            c0_read_fin  <= 1'b0;
            c0_write_fin <= 1'b0;
            c1_read_fin  <= 1'b0;
            c1_write_fin <= 1'b0;
            c0_rdata     <= '0;
            c1_rdata     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            c0_read_fin  <= 1'b0;
            c0_write_fin <= 1'b0;
            c1_read_fin  <= 1'b0;
            c1_write_fin <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        mem_we     <= grant1 ? c1_write_ce : c0_write_ce;
                        mem_addr   <= grant1 ? c1_addr : c0_addr;
                        mem_wdata  <= grant1 ? c1_wdata : c0_wdata;
                        mem_ce     <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (finishing) begin
                        mem_ce <= 1'b0;
                        state  <= DONE;
                        if (aborting) begin
                            timeout_err <= 1'b1;
                        end
                        if (!mem_we) begin
                            if (owner) begin
                                c1_rdata <= capture_data;
                            end else begin
                                c0_rdata <= capture_data;
                            end
                        end
                        c0_read_fin  <= !owner && !mem_we;
                        c0_write_fin <= !owner && mem_we;
                        c1_read_fin  <= owner && !mem_we;
                        c1_write_fin <= owner && mem_we;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers model the two caches, a responder
// models main memory, and a monitor compares memory requests and fin pulses.
module tb_mem_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic          port;
        logic          wr;
        logic [DW-1:0] rdata;
    } fin_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          c0_read_ce, c0_write_ce, c1_read_ce, c1_write_ce;
    logic [AW-1:0] c0_addr, c1_addr;
    logic [DW-1:0] c0_wdata, c1_wdata;
    logic          c0_read_fin, c0_write_fin, c1_read_fin, c1_write_fin;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic          mem_ce, mem_we, mem_ack, timeout_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int       checks = 0;
    int       errors = 0;
    int       ack_delay = 0;
    int       busy_cnt = 0;
    bit       never_ack = 1'b0;
    bit       stray_ack = 1'b0;
    bit       mon_en = 1'b0;
    logic     prev_ce = 1'b0;
    logic [62:0] cap = '0;

    req_t     req_q0[$];
    req_t     req_q1[$];
    req_t     mem_q[$];
    fin_exp_t fin_q[$];

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .c0_read_ce(c0_read_ce), .c0_write_ce(c0_write_ce), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_read_fin(c0_read_fin), .c0_write_fin(c0_write_fin), .c0_rdata(c0_rdata),
        .c1_read_ce(c1_read_ce), .c1_write_ce(c1_write_ce), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_read_fin(c1_read_fin), .c1_write_fin(c1_write_fin), .c1_rdata(c1_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rdataFor(input logic [AW-1:0] a);
        if (a == 30'h100) return 32'hDEADBEEF;
        return 32'h5A000000 | {2'b00, a};
    endfunction

    function automatic bit finSeen(input int port, input bit wr);
        if (port == 0) return wr ? c0_write_fin : c0_read_fin;
        return wr ? c1_write_fin : c1_read_fin;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic driveRequest(input int port, input bit wr, input bit rd,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 0) begin
            c0_write_ce = wr; c0_read_ce = rd; c0_addr = a; c0_wdata = d;
        end else begin
            c1_write_ce = wr; c1_read_ce = rd; c1_addr = a; c1_wdata = d;
        end
    endtask

    task automatic expectMem(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t m;
        m.wr = wr; m.addr = a; m.wdata = d;
        mem_q.push_back(m);
    endtask

    task automatic expectFin(input int port, input bit wr, input logic [DW-1:0] rd);
        fin_exp_t f;
        f.port = (port != 0); f.wr = wr; f.rdata = rd;
        fin_q.push_back(f);
    endtask

    // Expectations are queued in the order the arbiter should serve them.
    task automatic addRequest(input int port, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        r.wr = wr; r.addr = a; r.wdata = d;
        if (port == 0) req_q0.push_back(r);
        else req_q1.push_back(r);
        expectMem(wr, a, d);
        expectFin(port, wr, wr ? '0 : rdataFor(a));
    endtask

    task automatic applyStimulus(input int port);
        req_t r;
        bit   got;
        @(posedge clk); #1;
        while ((port == 0 && req_q0.size() > 0) || (port != 0 && req_q1.size() > 0)) begin
            if (port == 0) r = req_q0.pop_front();
            else r = req_q1.pop_front();
            driveRequest(port, r.wr, !r.wr, r.addr, r.wdata);
            got = 1'b0;
            for (int i = 0; i < 100 && !got; i++) begin
                @(negedge clk);
                got = finSeen(port, r.wr);
            end
            checkOutput("fin_wait", got, 1);
            @(posedge clk); #1;
        end
        driveRequest(port, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (stray_ack) begin
                mem_ack = 1'b1;
                mem_rdata = 32'hBAD0BAD0;
            end else if (mem_ce !== 1'b1) begin
                busy_cnt = 0;
            end else begin
                if (!never_ack && busy_cnt == ack_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdataFor(mem_addr);
                end
                busy_cnt++;
            end
        end
    end

    always @(negedge clk) begin : monitor
        int       nfin;
        req_t     me;
        fin_exp_t fe;
        nfin = int'(c0_read_fin) + int'(c0_write_fin) + int'(c1_read_fin) + int'(c1_write_fin);
        if (mon_en) begin
            if (mem_ce && !prev_ce) begin
                if (mem_q.size() == 0) begin
                    checkOutput("mem_unexpected", 1, 0);
                end else begin
                    me = mem_q.pop_front();
                    checkOutput("mem_we", mem_we, me.wr);
                    checkOutput("mem_addr", mem_addr, me.addr);
                    if (me.wr) checkOutput("mem_wdata", mem_wdata, me.wdata);
                end
                cap = {mem_we, mem_addr, mem_wdata};
            end else if (mem_ce) begin
                checkOutput("mem_frozen", {mem_we, mem_addr, mem_wdata}, cap);
            end
            if (nfin != 0) begin
                checkOutput("fin_onehot", nfin, 1);
                if (fin_q.size() == 0) begin
                    checkOutput("fin_unexpected", 1, 0);
                end else begin
                    fe = fin_q.pop_front();
                    checkOutput("fin_port_op", {c1_read_fin | c1_write_fin, c0_write_fin | c1_write_fin},
                                {fe.port, fe.wr});
                    if (!fe.wr) checkOutput("fin_rdata", fe.port ? c1_rdata : c0_rdata, fe.rdata);
                end
            end
        end
        prev_ce = mem_ce;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int ce_cycles;
        bit seen;
        driveRequest(0, 1'b0, 1'b0, '0, '0);
        driveRequest(1, 1'b0, 1'b0, '0, '0);
        applyReset();
        checkOutput("rst_mem_ce", mem_ce, 0);
        checkOutput("rst_fins", {c0_read_fin, c0_write_fin, c1_read_fin, c1_write_fin}, 0);
        checkOutput("rst_rdata", {c0_rdata, c1_rdata}, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        mon_en = 1'b1;

        // Single read on port 0, ack on the second BUSY cycle.
        ack_delay = 1;
        expectMem(1'b0, 30'h100, '0);
        expectFin(0, 1'b0, 32'hDEADBEEF);
        @(posedge clk); #1;
        driveRequest(0, 1'b0, 1'b1, 30'h100, '0);
        @(negedge clk); checkOutput("t1_ce_idle", mem_ce, 0);
        @(negedge clk);
        checkOutput("t1_ce", mem_ce, 1);
        checkOutput("t1_we", mem_we, 0);
        checkOutput("t1_addr", mem_addr, 30'h100);
        @(negedge clk);
        checkOutput("t1_ce_hold", mem_ce, 1);
        checkOutput("t1_fin_early", c0_read_fin, 0);
        @(negedge clk);
        checkOutput("t1_fin", c0_read_fin, 1);
        checkOutput("t1_rdata", c0_rdata, 32'hDEADBEEF);
        checkOutput("t1_ce_drop", mem_ce, 0);
        @(posedge clk); #1;
        driveRequest(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checkOutput("t1_fin_once", c0_read_fin, 0);
        checkOutput("t1_c1_quiet", {c1_read_fin, c1_write_fin, c1_rdata}, 0);

        // Same-cycle requests after reset: port 0 wins the first tie.
        applyReset();
        ack_delay = 0;
        addRequest(0, 1'b0, 30'h200, '0);
        addRequest(1, 1'b1, 30'h300, 32'hCAFEF00D);
        fork
            applyStimulus(0);
            applyStimulus(1);
        join

        // Fairness under continuous requests from both ports.
        repeat (2) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            addRequest(0, 1'b0, 30'h10 + AW'(i), '0);
            addRequest(1, 1'b1, 30'h20 + AW'(i), 32'h11110000 + DW'(i));
        end
        fork
            applyStimulus(0);
            applyStimulus(1);
        join

        // Write-back then refill on port 1.
        repeat (2) @(posedge clk);
        ack_delay = 1;
        addRequest(1, 1'b1, 30'h40, 32'h0BADF00D);
        addRequest(1, 1'b0, 30'h80, '0);
        applyStimulus(1);
        checkOutput("t4_c1_rdata", c1_rdata, rdataFor(30'h80));

        // A stray ack while idle must be ignored.
        @(posedge clk); #1;
        stray_ack = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b0;
        @(negedge clk);
        checkOutput("stray_no_ce", mem_ce, 0);
        checkOutput("stray_no_fin", {c0_read_fin, c0_write_fin, c1_read_fin, c1_write_fin}, 0);

        // Timeout: memory never answers.
        checkOutput("t5_err_clear", timeout_err, 0);
        never_ack = 1'b1;
        expectMem(1'b0, 30'h55, '0);
        expectFin(0, 1'b0, '0);
        @(posedge clk); #1;
        driveRequest(0, 1'b0, 1'b1, 30'h55, '0);
        ce_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (mem_ce) ce_cycles++;
            if (c0_read_fin) seen = 1'b1;
        end
        checkOutput("t5_fin_seen", seen, 1);
        checkOutput("t5_busy_cycles", ce_cycles, 8);
        checkOutput("t5_rdata", c0_rdata, 0);
        checkOutput("t5_err", timeout_err, 1);
        @(posedge clk); #1;
        driveRequest(0, 1'b0, 1'b0, '0, '0);
        never_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("t5_err_sticky", timeout_err, 1);

        // Reset in the middle of a transfer, then a normal request.
        ack_delay = 5;
        expectMem(1'b0, 30'h66, '0);
        @(posedge clk); #1;
        driveRequest(1, 1'b0, 1'b1, 30'h66, '0);
        repeat (2) @(negedge clk);
        checkOutput("t6_busy", mem_ce, 1);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_ce", mem_ce, 0);
        checkOutput("t6_rst_err", timeout_err, 0);
        checkOutput("t6_rst_rdata", c0_rdata, 0);
        driveRequest(1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        addRequest(1, 1'b0, 30'h77, '0);
        applyStimulus(1);
        checkOutput("t6_rdata", c1_rdata, rdataFor(30'h77));

        repeat (3) @(negedge clk);
        checkOutput("mem_q_empty", mem_q.size(), 0);
        checkOutput("fin_q_empty", fin_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
